rect_plotter: RTL and testbench
===============================

Name: rect_plotter

Overview:
- Pixel-write producer for the 320x240 framebuffer adapter. Drives the X/Y/colour/plot write interface that adapter consumes.
- Accepts one rectangle-draw command over a valid/ready handshake, then emits one clipped pixel write per clock in raster order.
- Pulses done when the rectangle is finished. Game logic (paddles, ball, erase, clear-screen) sits upstream and issues commands; this block is the only driver of the adapter's write port.

Parameters:
X_W, 9, width of x coordinate and width fields
Y_W, 8, width of y coordinate and height fields
COLOR_W, 3, colour width (1 bit per channel)
SCREEN_W, 320, visible columns; x >= SCREEN_W is clipped
SCREEN_H, 240, visible rows; y >= SCREEN_H is clipped

Ports:
clk  in  1  system clock, also the adapter clock
rst  in  1  asynchronous active-low reset
req_valid  in  1  command valid
req_ready  out  1  block can accept a command
req_x  in  X_W  top-left x
req_y  in  Y_W  top-left y
req_w  in  X_W  width in pixels
req_h  in  Y_W  height in pixels
req_colour  in  COLOR_W  fill colour
X  out  X_W  pixel x to adapter
Y  out  Y_W  pixel y to adapter
colour  out  COLOR_W  pixel colour to adapter
plot  out  1  pixel write strobe
done  out  1  one-cycle pulse, command complete

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - X=0, Y=0, colour=0, plot=0, done=0, req_ready=1 (req_ready is combinational: state==IDLE).
  - Asserting reset mid-draw drops plot immediately. The remaining pixels are discarded; there is no resume.
- States: IDLE, DRAW, DONE.
- IDLE:
  - req_ready=1.
  - On a clock edge with req_valid=1, the command is accepted:
    - Latch x0, y0, colour.
    - Compute x_end = min(req_x+req_w, SCREEN_W) and y_end = min(req_y+req_h, SCREEN_H), in X_W+1 and Y_W+1 bits, so there is no wrap-around.
  - If req_w==0, req_h==0, req_x>=SCREEN_W or req_y>=SCREEN_H, go to DONE with no pixels plotted.
  - Otherwise load cx=req_x, cy=req_y and go to DRAW.
- DRAW:
  - Combinational outputs: plot=1, X=cx, Y=cy, colour=latched colour. The first pixel is presented in the cycle after the accept edge (latency 1).
  - Each clock edge advances the position:
    - cx+1 when cx+1 < x_end.
    - Otherwise cx=x0 and cy+1.
    - When cx is the last column and cy+1 == y_end, go to DONE.
  - Exactly (x_end-x0)*(y_end-y0) consecutive plot cycles, with no gaps and no duplicate pixels.
  - req_valid is ignored; req_ready=0.
- DONE:
  - done=1 and plot=0 for exactly one cycle, then IDLE.
  - req_ready=0 in DONE, so the earliest next accept is the edge at the end of the first IDLE cycle.
- When plot=0, X/Y/colour hold their last values (adapter ignores them).
- No back-pressure from the adapter: it accepts one write per clock.
- Commands are not queued. Upstream must wait for req_ready.

Test Plan:
- Basic draw: accept (x=10,y=20,w=4,h=2,colour=5).
  - Required: 8 consecutive plot cycles starting the cycle after accept.
  - (X,Y) sequence: (10,20),(11,20),(12,20),(13,20),(10,21),(11,21),(12,21),(13,21), colour=5 throughout.
  - Then done=1 for 1 cycle, then req_ready=1.
- Degenerate sizes: w=0,h=5 and separately w=3,h=0.
  - Required: no plot cycle; done pulses the cycle after accept.
- Clipping: (x=318,y=238,w=4,h=4,colour=7).
  - Required: exactly 4 plots, (318,238),(319,238),(318,239),(319,239); then done.
- Off-screen: x=320,y=0,w=10,h=10, and separately x=0,y=240.
  - Required: zero plots, done pulse.
- Back-to-back with req_valid held high and two commands queued upstream:
  - req_ready=0 throughout DRAW and DONE.
  - The second command is accepted on the first IDLE edge; its first plot follows 1 cycle later.
  - The second command's latched values are unaffected by input changes during the first draw.
- Reset mid-draw: assert rst=0 during the 3rd pixel of a 10x10 draw.
  - Required: plot=0 and X=Y=colour=0 immediately (asynchronously); no done pulse.
  - After release: req_ready=1, and a new command draws normally from its own origin.

Source files
------------

// File: rtl/rect_plotter_if.sv
// rect_plotter_if: command channel into the rectangle plotter.
//   master : command issuer (game logic), drives req_valid and the rectangle fields
//   slave  : rect_plotter, drives req_ready
// Signals:
//   req_valid  command valid
//   req_ready  plotter can accept a command
//   req_x/y    top-left corner
//   req_w/h    width / height in pixels
//   req_colour fill colour
interface rect_plotter_if #(
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 3
);
  logic               req_valid;
  logic               req_ready;
  logic [X_W-1:0]     req_x;
  logic [Y_W-1:0]     req_y;
  logic [X_W-1:0]     req_w;
  logic [Y_W-1:0]     req_h;
  logic [COLOR_W-1:0] req_colour;

  modport master (
    output req_valid, req_x, req_y, req_w, req_h, req_colour,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_x, req_y, req_w, req_h, req_colour,
    output req_ready
  );
endinterface

// File: rtl/rect_plotter.sv
// rect_plotter: accepts one rectangle-fill command and emits one clipped pixel
// write per clock, in raster order, to the framebuffer adapter.
// Ports:
//   clk     system clock (also the adapter clock)
//   rst     asynchronous active-low reset
//   req     command channel (rect_plotter_if.slave); req_ready is high only in IDLE
//   X, Y    pixel coordinate to the adapter
//   colour  pixel colour to the adapter
//   plot    pixel write strobe, high for every DRAW cycle
//   done    one-cycle pulse after the last pixel (or after an empty command)
module rect_plotter #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic               clk,
  input  logic               rst,
  rect_plotter_if.slave      req,
  output logic [X_W-1:0]     X,
  output logic [Y_W-1:0]     Y,
  output logic [COLOR_W-1:0] colour,
  output logic               plot,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  // Screen limits widened by one bit so that x+w / y+h never wrap.
  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  state_t             state_reg, state_next;
  logic [X_W-1:0]     x0_reg, x0_next;
  logic [X_W:0]       x_end_reg, x_end_next;
  logic [Y_W:0]       y_end_reg, y_end_next;
  logic [X_W-1:0]     cx_reg, cx_next;
  logic [Y_W-1:0]     cy_reg, cy_next;
  logic [COLOR_W-1:0] colour_reg, colour_next;

  logic [X_W:0]       x_sum;
  logic [Y_W:0]       y_sum;
  logic [X_W:0]       cx_inc;
  logic [Y_W:0]       cy_inc;
  logic               empty_cmd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      x0_reg     <= '0;
      x_end_reg  <= '0;
      y_end_reg  <= '0;
      cx_reg     <= '0;
      cy_reg     <= '0;
      colour_reg <= '0;
    end else begin
      state_reg  <= state_next;
      x0_reg     <= x0_next;
      x_end_reg  <= x_end_next;
      y_end_reg  <= y_end_next;
      cx_reg     <= cx_next;
      cy_reg     <= cy_next;
      colour_reg <= colour_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    x0_next     = x0_reg;
    x_end_next  = x_end_reg;
    y_end_next  = y_end_reg;
    cx_next     = cx_reg;
    cy_next     = cy_reg;
    colour_next = colour_reg;

    x_sum  = {1'b0, req.req_x} + {1'b0, req.req_w};
    y_sum  = {1'b0, req.req_y} + {1'b0, req.req_h};
    cx_inc = {1'b0, cx_reg} + (X_W+1)'(1);
    cy_inc = {1'b0, cy_reg} + (Y_W+1)'(1);

    // Nothing visible to draw: zero-sized or origin already off-screen.
    empty_cmd = (req.req_w == '0) || (req.req_h == '0) ||
                ({1'b0, req.req_x} >= SCR_W) || ({1'b0, req.req_y} >= SCR_H);

    unique case (state_reg)
      IDLE: begin
        if (req.req_valid) begin
          x0_next    = req.req_x;
          x_end_next = (x_sum > SCR_W) ? SCR_W : x_sum;
          y_end_next = (y_sum > SCR_H) ? SCR_H : y_sum;
          if (empty_cmd) begin
            state_next = DONE;
          end else begin
            // Position/colour registers only move for a real draw so the
            // adapter-facing outputs keep their last values otherwise.
            // cy itself carries the row origin; no separate y0 is needed.
            cx_next     = req.req_x;
            cy_next     = req.req_y;
            colour_next = req.req_colour;
            state_next  = DRAW;
          end
        end
      end
      DRAW: begin
        if (cx_inc < x_end_reg) begin
          cx_next = cx_inc[X_W-1:0];
        end else if (cy_inc >= y_end_reg) begin
          // Last pixel: hold position so X/Y keep the final coordinate.
          state_next = DONE;
        end else begin
          cx_next = x0_reg;
          cy_next = cy_inc[Y_W-1:0];
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign req.req_ready = (state_reg == IDLE);
  assign plot          = (state_reg == DRAW);
  assign done          = (state_reg == DONE);
  assign X             = cx_reg;
  assign Y             = cy_reg;
  assign colour        = colour_reg;

endmodule

// File: tb/tb_rect_plotter.sv
module tb_rect_plotter;

  logic       clk;
  logic       rst;
  logic [8:0] X;
  logic [7:0] Y;
  logic [2:0] colour;
  logic       plot;
  logic       done;

  rect_plotter_if #(.X_W(9), .Y_W(8), .COLOR_W(3)) req_if ();

  rect_plotter #(
    .X_W(9), .Y_W(8), .COLOR_W(3), .SCREEN_W(320), .SCREEN_H(240)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req_if),
    .X      (X),
    .Y      (Y),
    .colour (colour),
    .plot   (plot),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  int done_seen     = 0;
  int done_expected = 0;
  logic [31:0] exp_q[$];
  logic prev_plot = 1'b0;
  logic prev_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_px(input int x, input int y, input int c);
    logic [8:0] xs;
    logic [7:0] ys;
    logic [2:0] cs;
    xs = x[8:0];
    ys = y[7:0];
    cs = c[2:0];
    return {12'b0, xs, ys, cs};
  endfunction

  // Reference model: push every visible pixel of the command in raster order.
  task automatic push_cmd(input int x, input int y, input int w, input int h,
                          input int c, output int n);
    int xe, ye;
    n  = 0;
    xe = (x + w > 320) ? 320 : x + w;
    ye = (y + h > 240) ? 240 : y + h;
    if (w > 0 && h > 0 && x < 320 && y < 240) begin
      for (int yy = y; yy < ye; yy++) begin
        for (int xx = x; xx < xe; xx++) begin
          exp_q.push_back(pack_px(xx, yy, c));
          n++;
        end
      end
    end
    done_expected++;
    $display("cmd x=%0d y=%0d w=%0d h=%0d c=%0d -> %0d pixels", x, y, w, h, c, n);
  endtask

  task automatic drive_req(input int x, input int y, input int w, input int h, input int c);
    req_if.req_x      = x[8:0];
    req_if.req_y      = y[7:0];
    req_if.req_w      = w[8:0];
    req_if.req_h      = h[7:0];
    req_if.req_colour = c[2:0];
    req_if.req_valid  = 1'b1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (req_if.req_ready) break;
    end
    check_eq("ready_wait", {31'b0, req_if.req_ready}, 32'd1);
  endtask

  // Issue one command and check first-cycle latency after the accept edge.
  task automatic send_cmd(input int x, input int y, input int w, input int h, input int c);
    int n;
    wait_ready();
    drive_req(x, y, w, h, c);
    push_cmd(x, y, w, h, c, n);
    @(posedge clk); #1;
    req_if.req_valid = 1'b0;
    @(negedge clk); #1;
    check_eq("lat_plot", {31'b0, plot}, (n > 0) ? 32'd1 : 32'd0);
    check_eq("lat_done", {31'b0, done}, (n > 0) ? 32'd0 : 32'd1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_seen == done_expected) break;
    end
    check_eq("done_count", done_seen, done_expected);
  endtask

  // Output monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (!rst) begin
      prev_plot = 1'b0;
      prev_done = 1'b0;
    end else begin
      check_eq("ready_idle_only", {31'b0, req_if.req_ready}, {31'b0, !(plot || done)});
      if (plot) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_plot", {31'b0, plot}, 32'd0);
        end else begin
          check_eq("pixel", {12'b0, X, Y, colour}, exp_q.pop_front());
        end
      end
      if (prev_plot && !plot) check_eq("no_gap", {31'b0, done}, 32'd1);
      if (prev_done) check_eq("done_one_cycle", {31'b0, done}, 32'd0);
      if (done) begin
        done_seen++;
        check_eq("q_empty_at_done", exp_q.size(), 32'd0);
      end
      prev_plot = plot;
      prev_done = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_compared);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst               = 1'b0;
    req_if.req_valid  = 1'b0;
    req_if.req_x      = '0;
    req_if.req_y      = '0;
    req_if.req_w      = '0;
    req_if.req_h      = '0;
    req_if.req_colour = '0;

    #12;
    check_eq("rst_X", {23'b0, X}, 32'd0);
    check_eq("rst_Y", {24'b0, Y}, 32'd0);
    check_eq("rst_colour", {29'b0, colour}, 32'd0);
    check_eq("rst_plot", {31'b0, plot}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_ready", {31'b0, req_if.req_ready}, 32'd1);
    #10 rst = 1'b1;

    // Basic draw, degenerate sizes, clipping, off-screen origins.
    send_cmd(10, 20, 4, 2, 5);    wait_done(100);
    send_cmd(30, 40, 0, 5, 3);    wait_done(20);
    send_cmd(30, 40, 3, 0, 3);    wait_done(20);
    send_cmd(318, 238, 4, 4, 7);  wait_done(50);
    send_cmd(320, 0, 10, 10, 1);  wait_done(20);
    send_cmd(0, 240, 10, 10, 1);  wait_done(20);
    send_cmd(0, 0, 1, 1, 6);      wait_done(20);
    send_cmd(315, 100, 200, 3, 2); wait_done(100);

    // Back-to-back: valid held high, inputs churn during the first draw.
    wait_ready();
    drive_req(20, 30, 3, 2, 1);
    push_cmd(20, 30, 3, 2, 1, n);
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      req_if.req_x      = 9'($urandom_range(0, 300));
      req_if.req_y      = 8'($urandom_range(0, 200));
      req_if.req_w      = 9'($urandom_range(1, 20));
      req_if.req_h      = 8'($urandom_range(1, 20));
      req_if.req_colour = 3'($urandom_range(0, 7));
      @(negedge clk); #1;
      if (done) break;
    end
    check_eq("b2b_first_done", {31'b0, done}, 32'd1);
    drive_req(100, 101, 2, 2, 4);
    push_cmd(100, 101, 2, 2, 4, n);
    @(negedge clk); #1;
    check_eq("b2b_idle_ready", {31'b0, req_if.req_ready}, 32'd1);
    @(posedge clk); #1;
    req_if.req_valid = 1'b0;
    @(negedge clk); #1;
    check_eq("b2b_latency", {31'b0, plot}, 32'd1);
    wait_done(50);

    // Reset during the third pixel of a 10x10 draw.
    send_cmd(50, 60, 10, 10, 2);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    exp_q.delete();
    done_expected--;
    #1;
    check_eq("mid_rst_plot", {31'b0, plot}, 32'd0);
    check_eq("mid_rst_X", {23'b0, X}, 32'd0);
    check_eq("mid_rst_Y", {24'b0, Y}, 32'd0);
    check_eq("mid_rst_colour", {29'b0, colour}, 32'd0);
    check_eq("mid_rst_done", {31'b0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("post_rst_ready", {31'b0, req_if.req_ready}, 32'd1);
    repeat (5) @(posedge clk);
    check_eq("no_done_after_rst", done_seen, done_expected);
    send_cmd(5, 7, 3, 2, 6);
    wait_done(50);

    repeat (4) @(posedge clk);
    check_eq("final_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
